// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream input, instruction-RAM write port and status of
//               the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_loader_if #(
    parameter int AW = 7
);
    logic [7:0]    s_data;
    logic          s_valid;
    logic          s_ready;
    logic          we;
    logic [AW-1:0] wa;
    logic [31:0]   wd;
    logic          cpu_reset;
    logic          done;
    logic          error;
    logic [AW:0]   words_loaded;

    // Stream source / RAM / CPU side
    modport master (
        output s_data, s_valid,
        input  s_ready, we, wa, wd, cpu_reset, done, error, words_loaded
    );

    // Loader side
    modport slave (
        input  s_data, s_valid,
        output s_ready, we, wa, wd, cpu_reset, done, error, words_loaded
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a header/payload/checksum byte stream, writes 32-bit
//               instruction words to RAM and releases the CPU on success.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  wire logic       clk,
    input  wire logic       reset,
    imem_loader_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_DATA = 3'd1,
        S_CSUM = 3'd2,
        S_DONE = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    localparam logic [31:0] c_depth = DEPTH;
    localparam logic [AW:0] c_one_n = 1;
    localparam logic [1:0]  c_one_b = 2'd1;

    state_t        r_state;
    logic          r_ready;
    logic          r_we;
    logic [AW-1:0] r_wa;
    logic [31:0]   r_wd;
    logic          r_cpu_reset;
    logic          r_done;
    logic          r_error;
    logic [AW:0]   r_words;
    logic [AW:0]   r_count;
    logic [AW:0]   r_widx;
    logic [1:0]    r_bcnt;
    logic [23:0]   r_asm;
    logic [7:0]    r_xor;

    logic          w_xfer;
    logic          w_hdr_ok;
    logic [AW:0]   w_hdr_n;
    logic          w_last_word;

    assign w_xfer      = bus.s_valid && r_ready;
    assign w_hdr_ok    = (bus.s_data != 8'd0) && ({24'd0, bus.s_data} <= c_depth);
    assign w_hdr_n     = (AW+1)'(bus.s_data);
    // Index is one bit wider than the RAM address so it never wraps within a load
    assign w_last_word = (r_widx == (r_count - c_one_n));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ready     <= 1'b1;
            r_we        <= 1'b0;
            r_wa        <= '0;
            r_wd        <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_words     <= '0;
            r_count     <= '0;
            r_widx      <= '0;
            r_bcnt      <= '0;
            r_asm       <= '0;
            r_xor       <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        if (w_hdr_ok) begin
                            r_count <= w_hdr_n;
                            r_bcnt  <= '0;
                            r_widx  <= '0;
                            r_xor   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_ready <= 1'b0;
                            r_error <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_xor  <= r_xor ^ bus.s_data;
                        r_bcnt <= r_bcnt + c_one_b;
                        if (r_bcnt == 2'd3) begin
                            // Bytes arrive LSB first, so the 4th byte lands on top
                            r_we    <= 1'b1;
                            r_wa    <= r_widx[AW-1:0];
                            r_wd    <= {bus.s_data, r_asm};
                            r_widx  <= r_widx + c_one_n;
                            r_words <= r_words + c_one_n;
                            if (w_last_word) begin
                                r_state <= S_CSUM;
                            end
                        end else begin
                            r_asm <= {bus.s_data, r_asm[23:8]};
                        end
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_ready <= 1'b0;
                        if (bus.s_data == r_xor) begin
                            r_done      <= 1'b1;
                            r_cpu_reset <= 1'b0;
                            r_state     <= S_DONE;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= S_ERR;
                        end
                    end
                end
                S_DONE: r_state <= S_DONE;
                S_ERR:  r_state <= S_ERR;
                default: begin
                    r_ready <= 1'b0;
                    r_error <= 1'b1;
                    r_state <= S_ERR;
                end
            endcase
        end
    end

    assign bus.s_ready      = r_ready;
    assign bus.we           = r_we;
    assign bus.wa           = r_wa;
    assign bus.wd           = r_wd;
    assign bus.cpu_reset    = r_cpu_reset;
    assign bus.done         = r_done;
    assign bus.error        = r_error;
    assign bus.words_loaded = r_words;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader against a word-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;
    localparam int DEPTH = 128;
    localparam int AW    = 7;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW)) bus ();
    imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_cmp = 0;
    int n_bad = 0;

    logic [AW-1:0] got_wa[$];
    logic [31:0]   got_wd[$];
    logic [31:0]   words[$];
    logic [7:0]    stream[$];

    always @(negedge clk) begin
        if (bus.we !== 1'b0) begin
            got_wa.push_back(bus.wa);
            got_wd.push_back(bus.wd);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Model: header N, each word LSB first, checksum = XOR of all payload bytes
    task automatic build_stream(input int hdr, input bit bad_csum);
        logic [31:0] x;
        logic [7:0]  cs;
        x = 32'd0;
        stream.delete();
        stream.push_back(8'(hdr));
        foreach (words[i]) begin
            x = x ^ words[i];
            for (int b = 0; b < 4; b++) stream.push_back(words[i][8*b +: 8]);
        end
        cs = x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
        if (bad_csum) cs = cs ^ 8'($urandom_range(255, 1));
        stream.push_back(cs);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        int waited;
        waited = 0;
        @(negedge clk);
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
            bus.s_valid = 1'b0;
            bus.s_data  = 8'($urandom);
            @(negedge clk);
        end
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (!bus.s_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.s_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL byte_accept: s_ready=%0b required 1 (byte %02h)", bus.s_ready, b);
            bus.s_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_stream(input int count, input int gap_pct);
        for (int i = 0; i < count; i++) send_byte(stream[i], gap_pct);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        got_wa.delete();
        got_wd.delete();
    endtask

    task automatic load_nominal_words();
        words.delete();
        words.push_back(32'hE3A000AA);
        words.push_back(32'hE3A01055);
        words.push_back(32'hEAFFFFFE);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({bus.s_ready, bus.we, bus.cpu_reset, bus.done, bus.error} !== 5'b10100) begin
            n_bad++;
            $display("FAIL reset_flags: ready/we/cpu_reset/done/error=%05b required 10100",
                     {bus.s_ready, bus.we, bus.cpu_reset, bus.done, bus.error});
        end
        n_cmp++;
        if (bus.wa !== '0 || bus.wd !== 32'd0 || bus.words_loaded !== '0) begin
            n_bad++;
            $display("FAIL reset_regs: wa=%h wd=%h words_loaded=%0d required 0/0/0",
                     bus.wa, bus.wd, bus.words_loaded);
        end
    endtask

    task automatic test_nominal(input int gap_pct, input string name);
        logic [7:0] nom [16] = '{8'h03, 8'hAA, 8'h00, 8'hA0, 8'hE3, 8'h55, 8'h10, 8'hA0,
                                 8'hE3, 8'hFE, 8'hFF, 8'hFF, 8'hEA, 8'hFB, 8'h00, 8'h00};
        do_reset();
        load_nominal_words();
        stream.delete();
        for (int i = 0; i < 14; i++) stream.push_back(nom[i]);
        send_stream(14, gap_pct);
        n_cmp++;
        if (got_wa.size() != 3) begin
            n_bad++;
            $display("FAIL %s_write_count: got %0d required 3", name, got_wa.size());
        end
        for (int i = 0; i < got_wa.size() && i < 3; i++) begin
            n_cmp++;
            if (got_wa[i] !== AW'(i) || got_wd[i] !== words[i]) begin
                n_bad++;
                $display("FAIL %s_write%0d: (%h,%h) required (%h,%h)",
                         name, i, got_wa[i], got_wd[i], AW'(i), words[i]);
            end
        end
        n_cmp++;
        if ({bus.s_ready, bus.cpu_reset, bus.done, bus.error} !== 4'b0010 || bus.words_loaded !== 8'd3) begin
            n_bad++;
            $display("FAIL %s_final: ready/cpu_reset/done/error=%04b words=%0d required 0010 words=3",
                     name, {bus.s_ready, bus.cpu_reset, bus.done, bus.error}, bus.words_loaded);
        end
    endtask

    task automatic test_bad_csum();
        do_reset();
        load_nominal_words();
        build_stream(3, 1'b0);
        stream[13] = 8'h00;
        send_stream(14, 0);
        n_cmp++;
        if (got_wa.size() != 3 || got_wd[2] !== 32'hEAFFFFFE) begin
            n_bad++;
            $display("FAIL bad_csum_writes: count=%0d required 3 ending EAFFFFFE", got_wa.size());
        end
        n_cmp++;
        if ({bus.s_ready, bus.cpu_reset, bus.done, bus.error} !== 4'b0101) begin
            n_bad++;
            $display("FAIL bad_csum_final: ready/cpu_reset/done/error=%04b required 0101",
                     {bus.s_ready, bus.cpu_reset, bus.done, bus.error});
        end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs [2] = '{8'h00, 8'h81};
        for (int h = 0; h < 2; h++) begin
            do_reset();
            stream.delete();
            stream.push_back(hdrs[h]);
            send_stream(1, 0);
            // Bytes offered while blocked must be ignored
            for (int k = 0; k < 6; k++) begin
                bus.s_valid = 1'b1;
                bus.s_data  = 8'($urandom);
                @(negedge clk);
            end
            bus.s_valid = 1'b0;
            n_cmp++;
            if (got_wa.size() != 0 || bus.words_loaded !== '0) begin
                n_bad++;
                $display("FAIL bad_header_%02h_writes: count=%0d words=%0d required 0/0",
                         hdrs[h], got_wa.size(), bus.words_loaded);
            end
            n_cmp++;
            if ({bus.s_ready, bus.cpu_reset, bus.done, bus.error} !== 4'b0101) begin
                n_bad++;
                $display("FAIL bad_header_%02h_final: ready/cpu_reset/done/error=%04b required 0101",
                         hdrs[h], {bus.s_ready, bus.cpu_reset, bus.done, bus.error});
            end
        end
    endtask

    task automatic test_reset_midload();
        do_reset();
        load_nominal_words();
        build_stream(3, 1'b0);
        send_stream(7, 0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (got_wa.size() != 1 || got_wa[0] !== '0 || got_wd[0] !== 32'hE3A000AA) begin
            n_bad++;
            $display("FAIL midload_first_write: count=%0d required 1 at wa=0 wd=E3A000AA", got_wa.size());
        end
        do_reset();
        repeat (4) @(negedge clk);
        n_cmp++;
        if (got_wa.size() != 0 || bus.s_ready !== 1'b1 || bus.words_loaded !== '0) begin
            n_bad++;
            $display("FAIL midload_after_reset: writes=%0d ready=%0b words=%0d required 0/1/0",
                     got_wa.size(), bus.s_ready, bus.words_loaded);
        end
        test_nominal(0, "midload_reload");
    endtask

    task automatic test_random_load(input int n, input bit bad, input int gap_pct, input string name);
        bit hdr_ok;
        int exp_writes;
        do_reset();
        words.delete();
        hdr_ok = (n >= 1 && n <= DEPTH);
        if (hdr_ok) for (int i = 0; i < n; i++) words.push_back($urandom);
        build_stream(n, bad);
        send_stream(hdr_ok ? stream.size() : 1, gap_pct);
        exp_writes = hdr_ok ? n : 0;
        n_cmp++;
        if (got_wa.size() != exp_writes || bus.words_loaded !== 8'(exp_writes)) begin
            n_bad++;
            $display("FAIL %s_count: writes=%0d words=%0d required %0d",
                     name, got_wa.size(), bus.words_loaded, exp_writes);
        end
        for (int i = 0; i < got_wa.size() && i < exp_writes; i++) begin
            if (got_wa[i] !== AW'(i) || got_wd[i] !== words[i]) begin
                n_cmp++; n_bad++;
                $display("FAIL %s_write%0d: (%h,%h) required (%h,%h)",
                         name, i, got_wa[i], got_wd[i], AW'(i), words[i]);
            end
        end
        if (exp_writes > 0) begin
            n_cmp++;
            if (got_wa[got_wa.size()-1] !== AW'(exp_writes - 1)) begin
                n_bad++;
                $display("FAIL %s_last_wa: %h required %h", name, got_wa[got_wa.size()-1], AW'(exp_writes - 1));
            end
        end
        n_cmp++;
        if ({bus.s_ready, bus.cpu_reset, bus.done, bus.error} !== ((hdr_ok && !bad) ? 4'b0010 : 4'b0101)) begin
            n_bad++;
            $display("FAIL %s_final: ready/cpu_reset/done/error=%04b required %04b", name,
                     {bus.s_ready, bus.cpu_reset, bus.done, bus.error},
                     (hdr_ok && !bad) ? 4'b0010 : 4'b0101);
        end
    endtask

    task automatic test_max_length();
        test_random_load(DEPTH, 1'b0, 0, "max_length");
    endtask

    task automatic test_random_streams();
        int n;
        for (int t = 0; t < 10; t++) begin
            case ($urandom_range(5))
                0:       n = 0;
                1:       n = $urandom_range(255, DEPTH + 1);
                default: n = $urandom_range(24, 1);
            endcase
            test_random_load(n, $urandom_range(3) == 0, $urandom_range(50), "random");
        end
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        test_reset();
        test_nominal(0, "nominal");
        test_bad_csum();
        test_bad_header();
        test_nominal(40, "backpressure");
        test_reset_midload();
        test_max_length();
        test_random_streams();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
